// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame controller: FSM states, window lanes
// and the default sobel_op latency.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SOBEL_LAT_DEFAULT = 4;

    // Byte lane of each neighbour in the 64-bit window (lane 7 = bits [63:56]).
    localparam int WIN_A0 = 7;
    localparam int WIN_A1 = 6;
    localparam int WIN_A2 = 5;
    localparam int WIN_A7 = 4;
    localparam int WIN_A3 = 3;
    localparam int WIN_A6 = 2;
    localparam int WIN_A5 = 1;
    localparam int WIN_A4 = 0;

endpackage

// File: rtl/sobel_linebuf.sv
// DEPTH-entry 8-bit circular line buffer: each enabled cycle returns the byte
// pushed DEPTH pushes ago and stores the new one in its place.
module sobel_linebuf #(
    parameter int DEPTH = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    assign o_data = r_mem[r_ptr];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame scheduler for the 3x3 Sobel pipeline: streams a frame out of memory,
// forms windows for sobel_op and writes mapped gradients to the edge map.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_W    = 19,
    parameter int SOBEL_LAT = SOBEL_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        threshold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [63:0]       win,
    input  logic [15:0]       gradient,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam logic [SOBEL_LAT-1:0] EARLY_MASK = {SOBEL_LAT{1'b1}} >> 1;

    state_t                           r_state, w_next;
    logic                             w_busy, w_done, w_accept, w_pipeBusy;
    logic [ADDR_W-1:0]                r_rdAddr;
    logic [7:0]                       r_thresh;
    logic                             r_rdValid;
    logic [CW-1:0]                    r_col;
    logic [RW-1:0]                    r_row;
    logic [ADDR_W-1:0]                r_inAddr;
    logic [7:0]                       w_rowUp1, w_rowUp2;
    logic [2:0][2:0][7:0]             r_win;
    logic                             r_winValid;
    logic [ADDR_W-1:0]                r_centre;
    logic [SOBEL_LAT-1:0]             r_vPipe;
    logic [SOBEL_LAT-1:0][ADDR_W-1:0] r_aPipe;
    logic [7:0]                       w_wrData;

    assign w_accept   = (r_state == ST_IDLE) && start;
    // The write in flight at the pipe tail does not hold the drain open.
    assign w_pipeBusy = r_rdValid | r_winValid | (|(r_vPipe & EARLY_MASK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_READ;
            ST_READ: begin
                w_busy = 1'b1;
                if (r_rdAddr == ADDR_W'(NPIX - 1)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (!w_pipeBusy) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdAddr  <= '0;
            r_thresh  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= (r_state == ST_READ);
            if (w_accept) begin
                r_rdAddr <= '0;
                r_thresh <= threshold;
            end else if (r_state == ST_READ && w_next == ST_READ) begin
                r_rdAddr <= r_rdAddr + ADDR_W'(1);
            end
        end
    end

    // Position counters describe the pixel currently on rd_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_inAddr   <= '0;
            r_win      <= '0;
            r_winValid <= 1'b0;
            r_centre   <= '0;
        end else if (w_accept) begin
            r_col      <= '0;
            r_row      <= '0;
            r_inAddr   <= '0;
            r_winValid <= 1'b0;
        end else begin
            r_winValid <= r_rdValid && (r_row >= RW'(2)) && (r_col >= CW'(2));
            r_centre   <= r_inAddr - ADDR_W'(IMG_W + 1);
            if (r_rdValid) begin
                r_inAddr <= r_inAddr + ADDR_W'(1);
                if (r_col == CW'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_rowUp2;
                r_win[1][2] <= w_rowUp1;
                r_win[2][2] <= rd_data;
            end
        end
    end

    sobel_linebuf #(.DEPTH(IMG_W)) u_lineBufUp1 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_rdValid),
        .i_data (rd_data),
        .o_data (w_rowUp1)
    );

    sobel_linebuf #(.DEPTH(IMG_W)) u_lineBufUp2 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_rdValid),
        .i_data (w_rowUp1),
        .o_data (w_rowUp2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vPipe <= '0;
            r_aPipe <= '0;
        end else begin
            r_vPipe[0] <= r_winValid;
            r_aPipe[0] <= r_centre;
            for (int i = 1; i < SOBEL_LAT; i++) begin
                r_vPipe[i] <= r_vPipe[i-1];
                r_aPipe[i] <= r_aPipe[i-1];
            end
        end
    end

    always_comb begin
        w_wrData = '0;
        if (r_vPipe[SOBEL_LAT-1]) begin
            if (r_thresh == 8'd0) begin
                w_wrData = (gradient > 16'd255) ? 8'hFF : gradient[7:0];
            end else begin
                w_wrData = (gradient >= {8'h00, r_thresh}) ? 8'hFF : 8'h00;
            end
        end
    end

    always_comb begin
        win = '0;
        win[WIN_A0*8 +: 8] = r_win[0][0];
        win[WIN_A1*8 +: 8] = r_win[0][1];
        win[WIN_A2*8 +: 8] = r_win[0][2];
        win[WIN_A7*8 +: 8] = r_win[1][0];
        win[WIN_A3*8 +: 8] = r_win[1][2];
        win[WIN_A6*8 +: 8] = r_win[2][0];
        win[WIN_A5*8 +: 8] = r_win[2][1];
        win[WIN_A4*8 +: 8] = r_win[2][2];
    end

    assign busy    = w_busy;
    assign done    = w_done;
    assign rd_addr = r_rdAddr;
    assign wr_en   = r_vPipe[SOBEL_LAT-1];
    assign wr_addr = r_aPipe[SOBEL_LAT-1];
    assign wr_data = w_wrData;

endmodule
